muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
//  Replaces the single-cycle a*b, a/b and a%b ALU paths and the fixed 32-bit hi/lo pair.
//  Adds signed modes, multiply-accumulate, a start/busy/done handshake and a divide-by-zero flag.
//  Sits beside the ALU; the control path drives start/op and stalls the PC while busy=1.
// PARAMETERS
//  WIDTH   32      operand width; HI/LO are each WIDTH bits; product is 2*WIDTH bits
//  HI_RST  'h32    HI value on reset (WIDTH bits)
//  LO_RST  'h16    LO value on reset (WIDTH bits)
// PORTS
//  clk          in   1      single clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request operation; sampled only in IDLE
//  op           in   3      000 MULU, 001 MUL, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD; 11x reserved
//  a            in   WIDTH  rs operand (multiplicand / dividend)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  hilo_we      in   1      direct write (MTHI/MTLO)
//  hilo_sel     in   1      1 = HI, 0 = LO, for the direct write
//  hilo_wdata   in   WIDTH  direct write data
//  busy         out  1      operation in progress; pipeline must stall
//  done         out  1      one-cycle pulse: HI/LO hold the new result
//  hi, lo       out  WIDTH  architectural HI/LO (read by MFHI/MFLO), registered
//  div_by_zero  out  1      last DIV/DIVU had b==0; cleared by the next accepted start
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, div_by_zero=0, hi=HI_RST, lo=LO_RST.
//   Reset mid-operation aborts it; no done pulse follows.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 with a legal op latches a, b and op; converts signed operands to magnitudes
//    and records the result signs; count=WIDTH-1; -> RUN.
//    start=1 with a reserved op is ignored.
//   RUN: one radix-2 step per cycle (shift-add multiply / restoring divide); -> FIX when count==0.
//   FIX: applies the sign correction, writes hi/lo, pulses done=1; -> IDLE.
//  Latency: start sampled at edge 1; RUN spans edges 2..WIDTH+1; hi/lo and done update at edge
//   WIDTH+2 (edge 34 for WIDTH=32).
//   busy=1 from after edge 1 until edge WIDTH+2; busy=0 in the done cycle.
//  Back-to-back: start in the done cycle is accepted, because the unit is already in IDLE.
//  Results:
//   MUL*: {hi,lo} = a*b over the full 2*WIDTH bits.
//   MADD*: {hi,lo} = {hi,lo} + a*b, taking {hi,lo} as they stood at the accepting edge;
//    wraps modulo 2^(2*WIDTH).
//   DIV*: lo = quotient, hi = remainder. Signed divide truncates toward zero; the remainder takes
//    the dividend's sign. MIN / -1 gives lo=MIN, hi=0 (wrap, no trap).
//  Divide by zero: no iteration is skipped and latency is unchanged; hi=a (raw), lo=all ones,
//   div_by_zero=1.
//  Direct write: hilo_we in IDLE with start=0 writes the selected register at the next edge.
//   - hilo_we while busy is dropped.
//   - start and hilo_we in the same cycle: start wins and the write is dropped.
//  hi/lo change only at the FIX edge, on a direct write, or on reset; they are stable otherwise.
//  start while busy is ignored and does not queue.
// STRUCTURE
//  Shared package muldiv_pkg: op encodings (OP_MULU..OP_MADD), FSM state enum {IDLE,RUN,FIX},
//   and a helper function is_signed_op().
//  Sub-module muldiv_iter_core: a combinational single-step shift-add/subtract datapath over
//   {acc, q} of 2*WIDTH+1 bits. It is instantiated once; the FSM, count and HI/LO live here.
// TESTING (WIDTH=32)
//  MULU a=FFFFFFFF b=2 -> done at edge 34, hi=1, lo=FFFFFFFE; busy=1 on edges 2..33.
//  MUL a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF, lo=FFFFFFEB; then DIV a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  DIVU a=1234 b=0 -> hi=1234, lo=FFFFFFFF, div_by_zero=1; next start of MULU clears the flag.
//  hilo_we sel=0 wdata=FFFFFFFF, sel=1 wdata=0; MADDU a=1 b=1 -> hi=1, lo=0.
//  Back-to-back: start DIVU 7/2 in the done cycle of a MULU -> lo=3, hi=1, 34 edges later.
//  Start MULU, rst=1 at edge 10 -> busy=0, hi=32, lo=16, and no done.
//   Also: start/hilo_we pulses while busy leave hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULU  = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MADDU = 3'b100;
    localparam logic [2:0] OP_MADD  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // 11x encodings are reserved
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

    // Signed modes convert operands to magnitudes and fix the sign afterwards
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic is_madd_op(input logic [2:0] op);
        return (op == OP_MADDU) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Control-path <-> multiply/divide unit bus, including HI/LO read-out.
interface muldiv_hilo_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_we;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: right-shift shift-add multiply or left-shift restoring divide over {acc, q}.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_sh;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    // Single step of either algorithm, selected by is_div
    always_comb begin
        mul_sum  = acc + (q[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opnd});
        div_diff = div_sh - {1'b0, opnd};
        acc_nxt  = {1'b0, mul_sum[WIDTH:1]};
        q_nxt    = {mul_sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            acc_nxt = div_ge ? div_diff : div_sh;
            q_nxt   = {q[WIDTH-2:0], div_ge};
        end
    end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide/MAC unit with architectural HI/LO registers.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned     WIDTH  = 32,
    parameter logic [WIDTH-1:0] HI_RST = WIDTH'('h32),
    parameter logic [WIDTH-1:0] LO_RST = WIDTH'('h16)
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_hilo_unit_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_e           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] a_raw;
    logic             div_r;
    logic             madd_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             b_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    mac;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div  (div_r),
        .acc     (acc),
        .q       (q),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt)
    );

    // Operand magnitudes at accept time and sign-corrected results at FIX time
    always_comb begin
        a_neg    = is_signed_op(bus.op) & bus.a[WIDTH-1];
        b_neg    = is_signed_op(bus.op) & bus.b[WIDTH-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        prod_mag = {acc[WIDTH-1:0], q};
        prod_s   = neg_q_r ? -prod_mag : prod_mag;
        mac      = {hi_r, lo_r} + prod_s;
        quo      = neg_q_r ? -q : q;
        rem      = neg_r_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Control FSM, iteration registers and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            div_r    <= 1'b0;
            madd_r   <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            b_zero_r <= 1'b0;
            hi_r     <= HI_RST;
            lo_r     <= LO_RST;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && is_legal_op(bus.op)) begin
                        state    <= RUN;
                        busy_r   <= 1'b1;
                        dbz_r    <= 1'b0;
                        count    <= CNT_W'(WIDTH - 1);
                        acc      <= '0;
                        div_r    <= is_div_op(bus.op);
                        madd_r   <= is_madd_op(bus.op);
                        neg_q_r  <= a_neg ^ b_neg;
                        neg_r_r  <= a_neg;
                        b_zero_r <= (bus.b == '0);
                        a_raw    <= bus.a;
                        if (is_div_op(bus.op)) begin
                            q    <= a_mag;
                            opnd <= b_mag;
                        end else begin
                            q    <= b_mag;
                            opnd <= a_mag;
                        end
                    end else if (bus.hilo_we && !bus.start) begin
                        if (bus.hilo_sel) hi_r <= bus.hilo_wdata;
                        else              lo_r <= bus.hilo_wdata;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    if (count == '0) state <= FIX;
                    else             count <= count - CNT_W'(1);
                end
                FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (div_r) begin
                        if (b_zero_r) begin
                            hi_r  <= a_raw;
                            lo_r  <= '1;
                            dbz_r <= 1'b1;
                        end else begin
                            hi_r <= rem;
                            lo_r <= quo;
                        end
                    end else if (madd_r) begin
                        {hi_r, lo_r} <= mac;
                    end else begin
                        {hi_r, lo_r} <= prod_s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit with directed vectors (WIDTH=32).
module tb_muldiv_hilo_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

    muldiv_hilo_unit #(
        .WIDTH  (W),
        .HI_RST (32'h32),
        .LO_RST (32'h16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare HI/LO/flag against the scoreboard on every done pulse
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("done_without_request", 64'(bus.done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("%s hi", mon_e.name), 64'(bus.hi), 64'(mon_e.hi));
                check($sformatf("%s lo", mon_e.name), 64'(bus.lo), 64'(mon_e.lo));
                check($sformatf("%s dbz", mon_e.name), 64'(bus.div_by_zero), 64'(mon_e.dbz));
            end
        end
    end

    // Issue one operation, then follow it to its done cycle checking timing and HI/LO stability
    task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz, input bit with_we, input bit poke);
        exp_t         e;
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;
        logic         busy_ok;
        logic         stable;
        int           lat;
        e.name = nm; e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb_q.push_back(e);
        hold_hi     = bus.hi;
        hold_lo     = bus.lo;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.start   = 1'b1;
        if (with_we) begin
            bus.hilo_we    = 1'b1;
            bus.hilo_sel   = 1'b0;
            bus.hilo_wdata = 32'h1234;
        end
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.hilo_we = 1'b0;
        check($sformatf("%s dbz_clear_on_start", nm), 64'(bus.div_by_zero), 64'd0);
        busy_ok = bus.busy;
        stable  = (bus.hi === hold_hi) && (bus.lo === hold_lo);
        lat     = 0;
        for (int k = 2; k <= 100; k++) begin
            if (poke && k == 6) begin
                bus.start      = 1'b1;
                bus.op         = OP_DIVU;
                bus.hilo_we    = 1'b1;
                bus.hilo_sel   = 1'b1;
                bus.hilo_wdata = 32'hDEAD;
            end
            @(posedge clk); #1;
            bus.start   = 1'b0;
            bus.hilo_we = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            busy_ok = busy_ok & bus.busy;
            stable  = stable & (bus.hi === hold_hi) & (bus.lo === hold_lo);
        end
        check($sformatf("%s done_edge", nm), 64'(lat), 64'(W + 2));
        check($sformatf("%s busy_while_running", nm), 64'(busy_ok), 64'd1);
        check($sformatf("%s busy_in_done_cycle", nm), 64'(bus.busy), 64'd0);
        check($sformatf("%s hilo_stable_while_busy", nm), 64'(stable), 64'd1);
    endtask

    // Direct MTHI/MTLO write from IDLE
    task automatic hilo_write(input logic sel, input logic [W-1:0] data,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo);
        bus.hilo_we    = 1'b1;
        bus.hilo_sel   = sel;
        bus.hilo_wdata = data;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        check("direct_write hi", 64'(bus.hi), 64'(ehi));
        check("direct_write lo", 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.op         = OP_MULU;
        bus.a          = '0;
        bus.b          = '0;
        bus.hilo_we    = 1'b0;
        bus.hilo_sel   = 1'b0;
        bus.hilo_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dbz", 64'(bus.div_by_zero), 64'd0);
        check("reset hi", 64'(bus.hi), 64'h32);
        check("reset lo", 64'(bus.lo), 64'h16);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mulu_ffffffff_x2", OP_MULU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 1'b0, 0, 0);
        run_op("b2b_divu_7_2",     OP_DIVU, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, 0, 0);
        run_op("mul_m3_x7",        OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, 0);
        run_op("div_m7_2",         OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, 0);
        run_op("divu_by_zero",     OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0, 0);
        check("dbz held after done", 64'(bus.div_by_zero), 64'd1);
        run_op("mulu_3_x5",        OP_MULU, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0, 0, 0);
        run_op("div_min_m1",       OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 0, 0);
        run_op("div_7_m2",         OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 0, 0);
        run_op("mul_min_min",      OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 0, 0);

        hilo_write(1'b0, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF);
        hilo_write(1'b1, 32'h0, 32'h0, 32'hFFFFFFFF);
        run_op("maddu_1_x1",       OP_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 1'b0, 0, 0);
        run_op("madd_m1_x1",       OP_MADD, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 0);

        // Reserved opcode is ignored
        bus.op    = 3'b110;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("reserved_op busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check("reserved_op busy later", 64'(bus.busy), 64'd0);
        check("reserved_op hi", 64'(bus.hi), 64'h0);
        check("reserved_op lo", 64'(bus.lo), 64'hFFFFFFFF);

        run_op("start_beats_write", OP_MULU, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1, 0);
        run_op("pokes_while_busy",  OP_MULU, 32'd4, 32'd4, 32'h0, 32'h10, 1'b0, 0, 1);

        // Reset in the middle of a multiply aborts it with no done pulse
        bus.op    = OP_MULU;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("abort busy before reset", 64'(bus.busy), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort hi", 64'(bus.hi), 64'h32);
        check("abort lo", 64'(bus.lo), 64'h16);
        rst = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        check("abort hi later", 64'(bus.hi), 64'h32);
        check("abort lo later", 64'(bus.lo), 64'h16);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
